// File: rtl/pam_tx_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pam_tx_pkg : state encoding and LFSR constants for the PAM transmit framer
// Revision   : 1.0
// ============================================================================
package pam_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_HEADER   = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_GAP      = 3'd4
   } state_e;

   localparam int PAM_ORDER_DEF = 4;
   localparam int SYM_W         = $clog2(PAM_ORDER_DEF);

   localparam int         LFSR_W     = 5;
   localparam logic [4:0] LFSR_SEED  = 5'b11111;
   localparam int         LFSR_TAP_A = 4;
   localparam int         LFSR_TAP_B = 2;

   localparam int HDR_W = 16;

   function automatic int sym_width(input int pam_order);
      return $clog2(pam_order);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pam_tx_frame_ctrl_m_seq_gen.sv
`default_nettype none
// ============================================================================
// m_seq_gen : 5-bit Fibonacci LFSR producing the 31-chip m-sequence
// Revision  : 1.0
// ============================================================================
module m_seq_gen
   import pam_tx_pkg::*;
(
   input  logic clk,
   input  logic arst_n,
   input  logic load,
   input  logic step,
   output logic chip
);

   logic [LFSR_W-1:0] lfsr_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         lfsr_q <= LFSR_SEED;
      end else if (load) begin
         lfsr_q <= LFSR_SEED;
      end else if (step) begin
         lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
      end
   end

   assign chip = lfsr_q[LFSR_W-1];

endmodule
`default_nettype wire

// File: rtl/pam_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// pam_tx_frame_ctrl : preamble / payload / gap sequencer for the PAM VLC link.
// Optional 16-bit sequence-number header when FRAME_HEADER_EN is defined.
// Revision          : 1.0
// ============================================================================
module pam_tx_frame_ctrl
   import pam_tx_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int PAM_ORDER     = PAM_ORDER_DEF,
   parameter int LENGTH_DATA   = 32,
   parameter int LENTGRH_M_SEQ = 31,
   parameter int GAP_CYCLES    = 8
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         ctrl_en,
   input  logic [DATA_WIDTH-1:0]        M_AXIS_tdata,
   input  logic                         M_AXIS_tlast,
   input  logic [DATA_WIDTH/8-1:0]      M_AXIS_tkeep,
   input  logic                         M_AXIS_tvalid,
   output logic                         M_AXIS_tready,
   output logic [$clog2(PAM_ORDER)-1:0] sym_data,
   output logic                         sym_valid,
   input  logic                         sym_ready,
   output logic                         sym_is_pre,
   output logic                         frame_start,
   output logic                         frame_done,
   output logic                         tlast_err,
   output logic                         busy
);

   localparam int SW     = sym_width(PAM_ORDER);
   localparam int S      = DATA_WIDTH / SW;
   localparam int SCNT_W = $clog2(S) + 1;
   localparam int WCNT_W = $clog2(LENGTH_DATA) + 1;
   localparam int GCNT_W = $clog2(GAP_CYCLES) + 1;

   localparam logic [SW-1:0]     SYM_MAX   = SW'(PAM_ORDER - 1);
   localparam logic [SCNT_W-1:0] SYM_LAST  = SCNT_W'(S - 1);
   localparam logic [WCNT_W-1:0] WORD_ALL  = WCNT_W'(LENGTH_DATA);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(LENGTH_DATA - 1);
   localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYCLES - 1);
   localparam logic [4:0]        CHIP_LAST = 5'(LENTGRH_M_SEQ - 1);

   state_e                  state_q;
   logic [4:0]              chip_cnt_q;
   logic [SCNT_W-1:0]       sym_cnt_q;
   logic [WCNT_W-1:0]       word_cnt_q;
   logic [GCNT_W-1:0]       gap_cnt_q;
   logic [DATA_WIDTH-1:0]   shreg_q;
   logic                    loaded_q;

`ifdef FRAME_HEADER_EN
   localparam int HDR_SYMS = HDR_W / SW;
   localparam int HCNT_W   = $clog2(HDR_SYMS) + 1;
   localparam logic [HCNT_W-1:0] HDR_LAST = HCNT_W'(HDR_SYMS - 1);

   logic [HDR_W-1:0]  seq_q;
   logic [HDR_W-1:0]  hdr_q;
   logic [HCNT_W-1:0] hdr_cnt_q;
`endif

   logic chip;
   logic sym_hs;
   logic pre_last;
   logic last_sym_hs;
   logic word_acc;

   assign sym_hs      = sym_valid && sym_ready;
   assign pre_last    = (state_q == ST_PREAMBLE) && sym_hs && (chip_cnt_q == CHIP_LAST);
   assign last_sym_hs = (state_q == ST_PAYLOAD) && sym_hs && (sym_cnt_q == SYM_LAST);

   // tready looks at this cycle's last-symbol handshake so consecutive words
   // stream without an empty slot in between.
   assign M_AXIS_tready = (state_q == ST_PAYLOAD) && (!loaded_q || last_sym_hs)
                          && (word_cnt_q < WORD_ALL);
   assign word_acc      = M_AXIS_tvalid && M_AXIS_tready;

   assign frame_start = (state_q == ST_PREAMBLE) && sym_hs && (chip_cnt_q == 5'd0);
   assign frame_done  = (state_q == ST_GAP) && sym_hs && (gap_cnt_q == GAP_LAST);
   assign tlast_err   = word_acc && ((M_AXIS_tlast != (word_cnt_q == WORD_LAST))
                                     || (M_AXIS_tkeep != '1));
   assign busy        = (state_q != ST_IDLE);
   assign sym_is_pre  = (state_q == ST_PREAMBLE);

   m_seq_gen u_m_seq_gen (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (pre_last),
      .step   ((state_q == ST_PREAMBLE) && sym_hs),
      .chip   (chip)
   );

   always_comb begin
      sym_data  = '0;
      sym_valid = 1'b0;
      case (state_q)
         ST_PREAMBLE: begin
            sym_valid = 1'b1;
            sym_data  = chip ? SYM_MAX : '0;
         end
`ifdef FRAME_HEADER_EN
         ST_HEADER: begin
            sym_valid = 1'b1;
            sym_data  = hdr_q[HDR_W-1 -: SW];
         end
`endif
         ST_PAYLOAD: begin
            sym_valid = loaded_q;
            sym_data  = shreg_q[DATA_WIDTH-1 -: SW];
         end
         ST_GAP: begin
            sym_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         chip_cnt_q <= '0;
         sym_cnt_q  <= '0;
         word_cnt_q <= '0;
         gap_cnt_q  <= '0;
         shreg_q    <= '0;
         loaded_q   <= 1'b0;
`ifdef FRAME_HEADER_EN
         seq_q      <= '0;
         hdr_q      <= '0;
         hdr_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ctrl_en && M_AXIS_tvalid) begin
                  state_q    <= ST_PREAMBLE;
                  chip_cnt_q <= '0;
               end
            end

            ST_PREAMBLE: begin
               if (sym_hs) begin
                  if (chip_cnt_q == CHIP_LAST) begin
                     chip_cnt_q <= '0;
                     word_cnt_q <= '0;
                     sym_cnt_q  <= '0;
                     loaded_q   <= 1'b0;
`ifdef FRAME_HEADER_EN
                     state_q    <= ST_HEADER;
                     hdr_q      <= seq_q;
                     hdr_cnt_q  <= '0;
`else
                     state_q    <= ST_PAYLOAD;
`endif
                  end else begin
                     chip_cnt_q <= chip_cnt_q + 5'd1;
                  end
               end
            end

`ifdef FRAME_HEADER_EN
            ST_HEADER: begin
               if (sym_hs) begin
                  hdr_q <= hdr_q << SW;
                  if (hdr_cnt_q == HDR_LAST) begin
                     hdr_cnt_q <= '0;
                     state_q   <= ST_PAYLOAD;
                  end else begin
                     hdr_cnt_q <= hdr_cnt_q + HCNT_W'(1);
                  end
               end
            end
`endif

            ST_PAYLOAD: begin
               if (word_acc) begin
                  shreg_q    <= M_AXIS_tdata;
                  loaded_q   <= 1'b1;
                  sym_cnt_q  <= '0;
                  word_cnt_q <= word_cnt_q + WCNT_W'(1);
               end else if (sym_hs) begin
                  if (sym_cnt_q == SYM_LAST) begin
                     loaded_q  <= 1'b0;
                     sym_cnt_q <= '0;
                     if (word_cnt_q == WORD_ALL) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= '0;
                     end
                  end else begin
                     shreg_q   <= shreg_q << SW;
                     sym_cnt_q <= sym_cnt_q + SCNT_W'(1);
                  end
               end
            end

            ST_GAP: begin
               if (sym_hs) begin
                  if (gap_cnt_q == GAP_LAST) begin
                     gap_cnt_q <= '0;
`ifdef FRAME_HEADER_EN
                     seq_q     <= seq_q + 16'd1;
`endif
                     if (ctrl_en && M_AXIS_tvalid) begin
                        state_q <= ST_PREAMBLE;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     gap_cnt_q <= gap_cnt_q + GCNT_W'(1);
                  end
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
